ext_mem_responder: RTL and testbench

- Responder (slave) end of the external-memory interface driven by inverted_residual_block.
- Sits in the bench and at the FPGA top as the external memory model/controller.
- Serves single-word read and write requests from the block's DMA (`request_extmem`, `write_extmem`, `addr_extmem`, `w_data`).
- Returns `valid_extmem`/`data_extmem` with programmable read latency, and keeps transaction counters and an out-of-range error flag.

---
 rtl/ext_mem_responder.sv | 153 +++++++++++++++
 tb/tb_ext_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// Responder end of the external-memory interface: single-word reads/writes with programmable
// read latency, transaction counters and a sticky out-of-range flag.
// Optional macro EXTMEM_STALL_EN adds 0..3 pseudo-random extra read-wait cycles from an LFSR.
module ext_mem_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_extmem,
    input  logic              write_extmem,
    input  logic [ADDR_W-1:0] addr_extmem,
    input  logic [DATA_W-1:0] w_data,
    output logic              valid_extmem,
    output logic [DATA_W-1:0] data_extmem,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_oob
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    // Wide enough for RD_LAT (max 15) plus 3 stall cycles.
    localparam int unsigned LatW = 5;
    localparam logic [ADDR_W:0] DepthExt = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

    state_e            state_q;
    logic [LatW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              oob_q;
    logic              wr_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic            req_oob;
    logic [IdxW-1:0] req_idx;
    logic            accept;
    logic [1:0]      extra;
    logic [LatW-1:0] rd_lat_total;

    assign req_oob      = ({1'b0, addr_extmem} >= DepthExt);
    assign req_idx      = addr_extmem[IdxW-1:0];
    assign accept       = (state_q == StIdle) && request_extmem;
    assign rd_lat_total = LatW'(RD_LAT) + LatW'(extra);

`ifdef EXTMEM_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci taps 8,6,5,4; steps once per accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else if (accept && !write_extmem) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign extra = lfsr_q[1:0];
`else
    assign extra = 2'b00;
`endif

    // Array contents survive reset, so it lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept && write_extmem && !req_oob) begin
            mem_q[req_idx] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            oob_q      <= 1'b0;
            wr_q       <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (request_extmem) begin
                        busy_q <= 1'b1;
                        idx_q  <= req_idx;
                        oob_q  <= req_oob;
                        wr_q   <= write_extmem;
                        if (req_oob) begin
                            err_q <= 1'b1;
                        end
                        if (write_extmem) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            data_q  <= '0;
                        end else if (rd_lat_total == LatW'(1)) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            data_q  <= req_oob ? '0 : mem_q[req_idx];
                        end else begin
                            state_q <= StRdWait;
                            cnt_q   <= rd_lat_total - LatW'(1);
                        end
                    end
                end
                StRdWait: begin
                    // Last wait cycle: the counter would reach zero here.
                    if (cnt_q == LatW'(1)) begin
                        state_q <= StResp;
                        valid_q <= 1'b1;
                        data_q  <= oob_q ? '0 : mem_q[idx_q];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - LatW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    busy_q  <= 1'b0;
                    if (wr_q) begin
                        wr_count_q <= wr_count_q + CNT_W'(1);
                    end else begin
                        rd_count_q <= rd_count_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid_extmem = valid_q;
    assign data_extmem  = data_q;
    assign busy         = busy_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign err_oob      = err_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: randomized and directed transactions compared
// against a transaction-level model (sparse memory, counters, latency from a reference LFSR).
module tb_ext_mem_responder;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 65536;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              err;

    int checks = 0;
    int errors = 0;

    bit [31:0]   mem_m [int unsigned];
    int unsigned rd_m;
    int unsigned wr_m;
    bit          err_m;
    bit [7:0]    lfsr_m;

    always #5 clk = ~clk;

    ext_mem_responder #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .request_extmem(req),
        .write_extmem  (wr),
        .addr_extmem   (addr),
        .w_data        (wdata),
        .valid_extmem  (valid),
        .data_extmem   (rdata),
        .busy          (busy),
        .rd_count      (rd_cnt),
        .wr_count      (wr_cnt),
        .err_oob       (err)
    );

    function automatic void model_reset();
        rd_m   = 0;
        wr_m   = 0;
        err_m  = 1'b0;
        lfsr_m = 8'hA5;
    endfunction

    // Expected latency of the next accepted read; steps the reference LFSR.
    function automatic int unsigned read_lat();
        int unsigned l;
        l = RD_LAT;
`ifdef EXTMEM_STALL_EN
        l = l + (lfsr_m % 4);
        lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
`endif
        return l;
    endfunction

    function automatic bit [31:0] model_read(input bit [31:0] a);
        if (a >= DEPTH) return 32'h0;
        if (mem_m.exists(a)) return mem_m[a];
        return 32'h0;
    endfunction

    task automatic txn(input bit w, input bit [31:0] a, input bit [31:0] d, input string name);
        int unsigned exp_lat;
        bit [31:0]   exp_d;
        int unsigned lat;
        bit          seen;
        exp_lat = w ? 1 : read_lat();
        exp_d   = w ? 32'h0 : model_read(a);
        if (w && a < DEPTH) mem_m[a] = d;
        if (a >= DEPTH) err_m = 1'b1;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, lat, seen, exp_lat);
        end
        checks++;
        if (rdata !== exp_d) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, rdata, exp_d);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy during pulse: got %b expected 1", name, busy);
        end
        if (w) wr_m++; else rd_m++;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after pulse: valid=%b data=%h busy=%b expected 0/0/0",
                     name, valid, rdata, busy);
        end
        checks++;
        if (rd_cnt !== CNT_W'(rd_m) || wr_cnt !== CNT_W'(wr_m) || err !== err_m) begin
            errors++;
            $display("FAIL %s counters: rd=%0d wr=%0d err=%b expected rd=%0d wr=%0d err=%b",
                     name, rd_cnt, wr_cnt, err, CNT_W'(rd_m), CNT_W'(wr_m), err_m);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (valid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake outputs: valid=%b data=%h busy=%b expected 0",
                     name, valid, rdata, busy);
        end
        checks++;
        if (rd_cnt !== '0 || wr_cnt !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s status outputs: rd=%0d wr=%0d err=%b expected 0",
                     name, rd_cnt, wr_cnt, err);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1 check_idle_zero("reset_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset_held");
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        txn(1'b1, 32'h10, 32'hDEADBEEF, "wr_0x10");
        txn(1'b0, 32'h10, 32'h0, "rd_0x10");
    endtask

    task automatic test_back_to_back();
        int unsigned exp_t [8];
        int unsigned acc_t;
        int unsigned t;
        int          k;
        bit [31:0]   exp_d;
        for (int i = 0; i < 8; i++) txn(1'b1, 32'(i), 32'h100 + 32'(i), "preload");
        acc_t = 0;
        for (int i = 0; i < 8; i++) begin
            exp_t[i] = acc_t + read_lat();
            acc_t    = exp_t[i] + 1;
        end
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = '0;
        t = 0;
        k = 0;
        while (k < 8 && t < 300) begin
            @(negedge clk);
            t++;
            if (valid === 1'b1) begin
                exp_d = model_read(32'(k));
                checks++;
                if (t != exp_t[k] || rdata !== exp_d) begin
                    errors++;
                    $display("FAIL burst pulse %0d: cycle=%0d data=%h expected cycle=%0d data=%h",
                             k, t, rdata, exp_t[k], exp_d);
                end
                rd_m++;
                k++;
                if (k < 8) addr = 32'(k);
                else req = 1'b0;
            end
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL burst timeout: got %0d pulses expected 8", k);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || rd_cnt !== CNT_W'(rd_m)) begin
            errors++;
            $display("FAIL burst end: valid=%b busy=%b rd=%0d expected 0/0/%0d",
                     valid, busy, rd_cnt, CNT_W'(rd_m));
        end
    endtask

    task automatic test_out_of_range();
        txn(1'b0, DEPTH, 32'h0, "oob_read");
        txn(1'b1, DEPTH + 1, 32'hBADBAD00, "oob_write");
        txn(1'b0, 32'h1, 32'h0, "addr1_intact");
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_read wait state: busy=%b valid=%b expected 1/0", busy, valid);
        end
        rst = 1'b0;
        #1 check_idle_zero("mid_read_reset");
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_read aborted pulse: got valid=1 expected none");
        end
        rst = 1'b1;
        txn(1'b0, 32'h10, 32'h0, "rd_after_reset");
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17; i++) txn(1'b1, 32'h200 + 32'(i), $urandom, "wrap_write");
        checks++;
        if (wr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL counter_wrap: wr_count=%0d expected 1", wr_cnt);
        end
    endtask

    task automatic test_random();
        bit          w;
        bit [31:0]   a;
        for (int i = 0; i < 30; i++) begin
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) a = DEPTH + $urandom_range(0, 100);
            else a = $urandom_range(0, 63);
            if (!w && a < DEPTH && !mem_m.exists(a)) w = 1'b1;
            txn(w, a, $urandom, w ? "rand_write" : "rand_read");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
